// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder.
//
// The operands are split into NUM_BLOCKS slices of BLOCK_WIDTH bits. Pipeline
// stage k resolves slice k. It forms the slice sum for carry-in 0 and carry-in 1
// side by side, then picks one of them with the carry registered by stage k-1.
// Stage 0 uses iCarry. The operand slices that are not yet added and the sum
// slices already resolved travel down the pipe with the carry. Each stage also
// holds a valid bit.
//
// Flow control: adv = !oValid || iReady. All stages move forward together when
// adv is 1. All stages hold when adv is 0. oReady equals adv.
//
// Ports
//   iClk       in   1   rising-edge clock
//   iRstN      in   1   asynchronous active-low reset
//   iA, iB     in   W   operands
//   iCarry     in   1   carry-in
//   iValid     in   1   operands valid
//   oReady     out  1   operands accepted this cycle
//   oSum       out  W   iA + iB + iCarry modulo 2^W
//   oCarry     out  1   unsigned carry-out
//   oOverflow  out  1   two's-complement overflow
//   oValid     out  1   result valid
//   iReady     in   1   downstream accepts the result
module pipelined_csa_adder #(
    parameter int ADDER_WIDTH = 32,
    parameter int BLOCK_WIDTH = 8
) (
    input  logic                   iClk,
    input  logic                   iRstN,
    input  logic [ADDER_WIDTH-1:0] iA,
    input  logic [ADDER_WIDTH-1:0] iB,
    input  logic                   iCarry,
    input  logic                   iValid,
    output logic                   oReady,
    output logic [ADDER_WIDTH-1:0] oSum,
    output logic                   oCarry,
    output logic                   oOverflow,
    output logic                   oValid,
    input  logic                   iReady
);
    localparam int W          = ADDER_WIDTH;
    // Clamped so that a bad BLOCK_WIDTH gives the check below, not a divide by zero.
    localparam int BW         = (BLOCK_WIDTH > 0) ? BLOCK_WIDTH : 1;
    localparam int NUM_BLOCKS = ADDER_WIDTH / BW;

    if (BLOCK_WIDTH < 1 || ADDER_WIDTH < 1 || (ADDER_WIDTH % BW) != 0) begin : g_bad_params
        $error("pipelined_csa_adder: ADDER_WIDTH must be a positive multiple of BLOCK_WIDTH >= 1");
    end

    logic adv;
    assign adv    = !oValid || iReady;
    assign oReady = adv;

    // Inputs seen by each stage. Index 0 is the block inputs. Index k is driven
    // from the registers of stage k-1.
    logic [W-1:0] stg_a [NUM_BLOCKS];
    logic [W-1:0] stg_b [NUM_BLOCKS];
    logic [W-1:0] stg_s [NUM_BLOCKS];
    logic         stg_c [NUM_BLOCKS];
    logic         stg_v [NUM_BLOCKS];

    assign stg_a[0] = iA;
    assign stg_b[0] = iB;
    assign stg_s[0] = '0;
    assign stg_c[0] = iCarry;
    assign stg_v[0] = iValid;

    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_stage
        logic [BW:0]  sum0;
        logic [BW:0]  sum1;
        logic [BW:0]  sel;
        logic [W-1:0] s_d;
        logic [W-1:0] s_q;
        logic         c_q;
        logic         v_q;

        assign sum0 = {1'b0, stg_a[k][k*BW +: BW]} + {1'b0, stg_b[k][k*BW +: BW]};
        assign sum1 = {1'b0, stg_a[k][k*BW +: BW]} + {1'b0, stg_b[k][k*BW +: BW]} + (BW+1)'(1);
        assign sel  = stg_c[k] ? sum1 : sum0;
        // Sum bits above the slices resolved so far are always zero, so OR-ing
        // in this slice is enough.
        assign s_d  = stg_s[k] | (W'(sel[BW-1:0]) << (k*BW));

        if (k < NUM_BLOCKS - 1) begin : g_fwd
            logic [W-1:0] a_q;
            logic [W-1:0] b_q;

            always_ff @(posedge iClk or negedge iRstN) begin
                if (!iRstN) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    a_q <= stg_a[k];
                    b_q <= stg_b[k];
                    s_q <= s_d;
                    c_q <= sel[BW];
                    v_q <= stg_v[k];
                end
            end

            assign stg_a[k+1] = a_q;
            assign stg_b[k+1] = b_q;
            assign stg_s[k+1] = s_q;
            assign stg_c[k+1] = c_q;
            assign stg_v[k+1] = v_q;
        end else begin : g_last
            logic msb_cin;
            logic ovf_d;
            logic ovf_q;
            logic unused_ab;

            // The carry into the MSB is recovered from the selected MSB sum bit.
            assign msb_cin   = sel[BW-1] ^ stg_a[k][W-1] ^ stg_b[k][W-1];
            assign ovf_d     = msb_cin ^ sel[BW];
            assign unused_ab = ^{stg_a[k], stg_b[k]};

            always_ff @(posedge iClk or negedge iRstN) begin
                if (!iRstN) begin
                    s_q   <= '0;
                    c_q   <= 1'b0;
                    v_q   <= 1'b0;
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    s_q   <= s_d;
                    c_q   <= sel[BW];
                    v_q   <= stg_v[k];
                    ovf_q <= ovf_d;
                end
            end

            assign oSum      = s_q;
            assign oCarry    = c_q;
            assign oOverflow = ovf_q;
            assign oValid    = v_q;
        end
    end
endmodule

// File: doc/pipelined_csa_adder.md
PIPELINED_CSA_ADDER -- requirements
Module: pipelined_csa_adder

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 32: total operand and sum width in bits.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 8: bits per carry-select block, which is also bits resolved per pipeline stage.
REQ-003 SHALL derive NUM_BLOCKS = ADDER_WIDTH/BLOCK_WIDTH; ADDER_WIDTH not a multiple of BLOCK_WIDTH, or BLOCK_WIDTH < 1, SHALL be an elaboration error.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 iClk  input  1  rising-edge clock.
REQ-006 iRstN  input  1  asynchronous active-low reset.
REQ-007 iA, iB  input  ADDER_WIDTH  operands.
REQ-008 iCarry  input  1  carry-in.
REQ-009 iValid  input  1  operands valid.
REQ-010 oReady  output  1  block accepts operands this cycle.
REQ-011 oSum  output  ADDER_WIDTH  iA+iB+iCarry modulo 2^ADDER_WIDTH.
REQ-012 oCarry  output  1  unsigned carry-out.
REQ-013 oOverflow  output  1  two's-complement signed overflow.
REQ-014 oValid  output  1  result valid.
REQ-015 iReady  input  1  downstream accepts the result.

Function
REQ-016 Pipeline SHALL have NUM_BLOCKS stages; stage k SHALL resolve bits [k*BLOCK_WIDTH +: BLOCK_WIDTH].
REQ-017 Each stage SHALL compute block sum and carry for both carry-in=0 and carry-in=1 in parallel, then select using the registered carry from stage k-1; stage 0 SHALL use the captured iCarry.
REQ-018 Unresolved upper operand slices and resolved lower sum slices SHALL be carried forward in per-stage registers; each stage SHALL hold a valid bit.
REQ-019 Transfer in SHALL occur when iValid && oReady at a rising edge.
REQ-020 Transfer out SHALL occur when oValid && iReady at a rising edge.
REQ-021 Global advance SHALL be defined as adv = !oValid || iReady; oReady SHALL equal adv, combinationally, with no dependence on iValid.
REQ-022 When adv=1, every stage register SHALL load from its predecessor, and stage 0 SHALL load the inputs with valid = iValid.
REQ-023 When adv=0, all stage registers, including data and valid bits, SHALL hold their values.
REQ-024 Latency SHALL be exactly NUM_BLOCKS cycles from accept to oValid when not stalled.
REQ-025 Sustained throughput SHALL be one result per cycle when iReady=1.
REQ-026 oSum, oCarry, oOverflow and oValid SHALL be driven directly from the last stage register.
REQ-027 Output ordering SHALL equal input ordering; no result SHALL be dropped or duplicated.
REQ-028 While oValid=1 and iReady=0, all outputs SHALL remain stable.
REQ-029 oOverflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-030 Bubbles, i.e. cycles with iValid=0, SHALL propagate as invalid stages and SHALL NOT corrupt neighbouring results.
REQ-031 When NUM_BLOCKS=1, the block SHALL degenerate to a single registered carry-select adder with latency 1.

Reset
REQ-032 When iRstN=0, all stage valid bits SHALL clear immediately, without waiting for a clock edge.
REQ-033 During reset, oValid, oSum, oCarry and oOverflow SHALL read 0.
REQ-034 Datapath registers SHALL reset to 0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight results; none SHALL appear after release.
REQ-036 oReady SHALL be 1 during reset and after release, since oValid=0.
REQ-037 The first accept SHALL be possible on the first rising edge after iRstN deasserts.

Verification
REQ-038 Default params, iA=0xFFFFFFFF, iB=0x00000001, iCarry=0, iReady=1 -> after 4 cycles: oSum=0x00000000, oCarry=1, oOverflow=0, oValid=1 for one cycle.
REQ-039 iA=0x7FFFFFFF, iB=0, iCarry=1 -> oSum=0x80000000, oCarry=0, oOverflow=1; iA=0x80000000, iB=0x80000000, iCarry=0 -> oSum=0, oCarry=1, oOverflow=1.
REQ-040 Back-to-back stream of 100 random operands with iValid=1 and iReady=1 -> 100 results, in order, matching a reference model, one per cycle after the 4-cycle fill.
REQ-041 Random iValid and random iReady (50%) over 1000 transactions -> no loss or duplication; outputs stable while oValid=1 && iReady=0; oReady=0 exactly when oValid=1 && iReady=0.
REQ-042 Pulse iRstN low asynchronously mid-cycle with 3 operands in flight -> oValid=0 at once; after release, no stale results appear, and the next accepted operand emerges after 4 cycles.
REQ-043 Parameter sweep (ADDER_WIDTH, BLOCK_WIDTH) = (8,8), (16,4), (64,16) with random operands -> correct sums; latencies of 1, 4 and 4 cycles respectively.
